// File: rtl/limn2600_cache_ctrl.sv
// limn2600_cache_ctrl
// Sequencing controller for the Limn2600 hashed direct-mapped cache data
// array. Round-robin arbitration between fetch (i) and load/store (d),
// a private tag/valid store, and a single-word memory bus for misses
// and write-through/write-allocate stores.
//
// Handshake semantics (all ports):
//   i_req/d_req: the requester raises req with its command fields and holds
//     them stable until it sees the one-cycle ack. It must drop or replace
//     req by the rising edge that ends the ack cycle; requests are not
//     sampled while an ack is being issued.
//   m_req: held high with m_addr/m_we/m_wdata stable until m_ack is seen;
//     m_rdata is taken in the m_ack cycle and m_req falls the cycle after.
module limn2600_cache_ctrl #(
  parameter int NUM_ENTRIES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // invalidate-all pulse
  input  logic        flush,
  // data array
  output logic        c_we,
  output logic [31:0] c_addr_in,
  output logic [31:0] c_data_in,
  output logic [31:0] c_addr_out,
  input  logic [31:0] c_data_out,
  // memory bus
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  // debug view of the sequencing FSM
  output logic [2:0]  state_dbg
);

  localparam int INDEX_BITS = $clog2(NUM_ENTRIES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  // Same hash the data array uses, so both agree on where a word lives.
  function automatic logic [INDEX_BITS-1:0] hash_idx(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    x = (x >> 16) ^ x;
    return INDEX_BITS'(x);
  endfunction

  logic [2:0]             state;
  logic                   owner_d;       // 1: current transaction belongs to d
  logic                   we_q;          // current transaction is a store
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            data_q;        // hit or memory read data
  logic                   last_grant_d;  // 1: d was granted most recently
  logic                   flush_pend;
  logic [NUM_ENTRIES-1:0] valid;
  logic [31:0]            tag_mem [NUM_ENTRIES];

  logic                   grant_i;
  logic                   grant_d;
  logic [31:0]            gnt_addr;
  logic [INDEX_BITS-1:0]  idx;
  logic                   hit;
  logic [31:0]            fill_data;

  // Arbitration: only in IDLE with no flush waiting; ties go to the
  // requester that was not granted last.
  always_comb begin
    grant_i  = (state == S_IDLE) && !flush_pend && i_req && (!d_req || last_grant_d);
    grant_d  = (state == S_IDLE) && !flush_pend && d_req && !grant_i;
    gnt_addr = grant_d ? d_addr : i_addr;
  end

  // Tag compare and fill data for the latched transaction.
  always_comb begin
    idx       = hash_idx(addr_q);
    hit       = valid[idx] && (tag_mem[idx] == addr_q);
    fill_data = we_q ? wdata_q : data_q;
  end

  // Sequencing FSM, request latch, round-robin pointer, valid vector and
  // pending flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      owner_d      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      data_q       <= 32'h0;
      last_grant_d <= 1'b1;
      flush_pend   <= 1'b0;
      valid        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (grant_i || grant_d) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            we_q         <= grant_d && d_we;
            addr_q       <= gnt_addr;
            wdata_q      <= d_wdata;
            state        <= (grant_d && d_we) ? S_MEM_WR : S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            data_q <= c_data_out;
            state  <= S_RESP;
          end else begin
            state  <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (m_ack) begin
            data_q <= m_rdata;
            state  <= S_FILL;
          end
        end
        S_MEM_WR: begin
          if (m_ack) state <= S_FILL;
        end
        S_FILL: begin
          valid[idx] <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // A new flush pulse always leaves a pending flush behind, even when
      // it lands in the IDLE cycle that applies an older one.
      if (flush) flush_pend <= 1'b1;
    end
  end

  // Tag RAM: written on every fill, never reset (the valid vector guards it).
  always_ff @(posedge clk) begin
    if (state == S_FILL) tag_mem[idx] <= addr_q;
  end

  // Outputs decode from state so that an asynchronous reset drops the
  // memory request and data-array write immediately.
  always_comb begin
    c_addr_out = (grant_i || (grant_d && !d_we)) ? gnt_addr : 32'h0;
    m_req      = (state == S_MEM_RD) || (state == S_MEM_WR);
    m_we       = (state == S_MEM_WR);
    m_addr     = m_req ? addr_q : 32'h0;
    m_wdata    = m_we ? wdata_q : 32'h0;
    c_we       = (state == S_FILL);
    c_addr_in  = c_we ? addr_q : 32'h0;
    c_data_in  = c_we ? fill_data : 32'h0;
    i_ack      = (state == S_RESP) && !owner_d;
    d_ack      = (state == S_RESP) && owner_d;
    i_data     = i_ack ? data_q : 32'h0;
    d_rdata    = (d_ack && !we_q) ? data_q : 32'h0;
    state_dbg  = state;
  end

endmodule

// File: doc/limn2600_cache_ctrl.md
# limn2600_cache_ctrl

Sequencing controller for the Limn2600 hashed direct-mapped cache data array. It shares the array between the instruction-fetch and load/store requesters with round-robin arbitration. It keeps the tag/valid store that the data array lacks, and it services misses and write-through stores over the single-word memory bus.

## Interface
- NUM_ENTRIES, 1024, entries in the data array; power of two; INDEX_BITS = log2(NUM_ENTRIES)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; i_addr, held until i_ack
- i_addr  in  32  fetch word address
- i_ack  out  1  one-cycle completion pulse
- i_data  out  32  fetch data, valid while i_ack=1
- d_req  in  1  load/store request; d_we, d_addr, d_wdata held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  load/store address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  load data, valid while d_ack=1 (0 for stores)
- flush  in  1  single-cycle pulse; invalidate all entries
- c_we, c_addr_in[31:0], c_data_in[31:0]  out  data-array write port
- c_addr_out  out  32  data-array read address
- c_data_out  in  32  data-array read data, registered one cycle after c_addr_out
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_ack  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  32  memory read data

## Operation
- Index rule: idx = H(addr) & (NUM_ENTRIES-1). H is 32-bit truncating: x=((x>>16)^x)*32'h45d9f3b twice, then x=(x>>16)^x. This is identical to the data array's hash.
- Tag store: NUM_ENTRIES x 32-bit full-address tags (RAM, no reset) plus a NUM_ENTRIES-bit valid vector (flops, reset 0).
- FSM states: IDLE, CHECK, MEM_RD, MEM_WR, FILL, RESP.
- IDLE:
  - If flush_pend: clear all valid bits, clear flush_pend, grant nothing this cycle.
  - Otherwise arbitrate between i_req and d_req.
  - Both requesting: grant the requester not granted last; the last-grant pointer resets to d, so i wins the first tie.
  - Granted load or fetch: c_addr_out=addr, latch the request, go to CHECK.
  - Granted store: go to MEM_WR.
- CHECK: tag compare (valid[idx] && tag[idx]==addr).
  - Hit: latch c_data_out as the response, go to RESP.
  - Miss: go to MEM_RD.
- MEM_RD: m_req=1, m_we=0, m_addr=addr. On m_ack, latch m_rdata and go to FILL.
- MEM_WR: m_req=1, m_we=1, m_addr=addr, m_wdata=wdata. On m_ack, go to FILL. Write-through, write-allocate.
- FILL: c_we=1, c_addr_in=addr, c_data_in=latched data; tag[idx]=addr, valid[idx]=1. Go to RESP.
- RESP: assert the owner's ack with data for one cycle, then go to IDLE. Requests are not sampled in RESP. The requester must drop or replace req by the edge ending the ack cycle.
- flush asserted in any state sets flush_pend. It is applied in the next IDLE cycle, before any grant.
- Aliasing: a different address at the same idx misses and replaces the entry.

## Timing
- Reset values: state IDLE; i_ack, d_ack, m_req, m_we, c_we = 0; all address/data outputs 0; valid vector 0; flush_pend 0; last-grant = d.
- Reset mid-operation: m_req and c_we drop asynchronously and the transaction is abandoned. No ack is ever issued for it.
- Read hit latency: req sampled at edge 0 (IDLE), CHECK in cycle 1, ack in cycle 2.
- Read miss latency: 3 + memory wait cycles. m_req asserts in the cycle after CHECK; FILL runs in the cycle after m_ack; ack follows.
- Store latency: MEM_WR from cycle 1; FILL the cycle after m_ack; ack the next cycle.
- m_addr, m_we and m_wdata are stable for the whole time m_req=1. m_req deasserts in the cycle after m_ack.
- c_we is high for exactly one cycle per fill or store.
- A loser of arbitration waits and is granted at the next IDLE, ahead of a re-requesting winner.

## Test plan
- Cold read: after reset, i_req with i_addr=0x1000 and memory returns 0xDEADBEEF after 3 wait cycles. Required: m_req with m_addr=0x1000, one c_we with c_data_in=0xDEADBEEF, i_ack with i_data=0xDEADBEEF. A repeat read gets i_ack 2 cycles after req with no m_req.
- Store then load: d_we=1, d_addr=0x2000, d_wdata=0x12345678. Required: memory write, then d_ack with d_rdata=0. A following load from 0x2000 hits (no m_req) and returns 0x12345678.
- Contention: i_req and d_req asserted together and held through three ack cycles each. Required grant order i, d, i, d, with no ack on both ports in the same cycle.
- Aliasing: two addresses with equal idx (found by bench search). Required: read A (miss), read B (miss, replaces A), read A again misses with m_req asserted.
- Flush during miss: flush pulsed while in MEM_RD for 0x3000. Required: the miss completes and acks; the next read of 0x3000 misses.
- Async reset while m_req=1. Required: m_req=0 immediately with no edge needed, no ack for the abandoned transaction, and the previously cached address misses after reset.
